spu_local_store: RTL and testbench

- Parametrised successor to the SPU data memory.
- N-port quadword local store:
  - NUM_PORTS read/write data ports with byte-enable writes and registered reads.
  - One registered instruction-fetch port.
  - One DMA burst-fill engine with a valid/ready stream that shares port 0's write slot.
- Sits between the SPU load/store pipes, the fetch unit and the MFC/DMA interface.

---
 rtl/spu_local_store_pkg.sv | 27 ++
 rtl/spu_local_store_if.sv | 59 +++++
 rtl/spu_local_store_dma.sv | 79 +++++++
 rtl/spu_local_store.sv | 108 ++++++++++
 tb/tb_spu_local_store.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_local_store_pkg.sv
// spu_local_store shared types: default widths, DMA FSM states
// and a byte-enable merge helper.
package spu_ls_pkg;

    localparam int DATA_W = 128;
    localparam int BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE,
        BURST,
        DONE
    } dma_state_t;

    // Bytes with be set come from new_d, the rest keep old_d.
    function automatic logic [DATA_W-1:0] byte_merge(
        input logic [DATA_W-1:0] old_d,
        input logic [DATA_W-1:0] new_d,
        input logic [BE_W-1:0]   be
    );
        logic [DATA_W-1:0] r;
        r = old_d;
        for (int b = 0; b < BE_W; b++)
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/spu_local_store_if.sv
// spu_local_store bus bundle: data ports, fetch port, DMA stream.
// LS_PARITY_EN adds the p_perr/if_perr parity-error outputs.
interface spu_local_store_if #(
    parameter int NUM_PORTS = 2,
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 14,
    parameter int LEN_W     = 8
);
    localparam int BE_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        p_req;
    logic [NUM_PORTS-1:0]        p_we;
    logic [NUM_PORTS*ADDR_W-1:0] p_addr;
    logic [NUM_PORTS*BE_W-1:0]   p_be;
    logic [NUM_PORTS*DATA_W-1:0] p_wdata;
    logic [NUM_PORTS*DATA_W-1:0] p_rdata;
    logic [NUM_PORTS-1:0]        p_rvalid;
    logic [ADDR_W-1:0]           if_addr;
    logic                        if_req;
    logic [DATA_W-1:0]           if_data;
    logic                        if_valid;
    logic                        dma_start;
    logic [ADDR_W-1:0]           dma_addr;
    logic [LEN_W-1:0]            dma_len;
    logic                        dma_wvalid;
    logic [DATA_W-1:0]           dma_wdata;
    logic                        dma_wready;
    logic                        dma_busy;
    logic                        dma_done;
`ifdef LS_PARITY_EN
    logic [NUM_PORTS-1:0]        p_perr;
    logic                        if_perr;
`endif

    modport master (
        output p_req, p_we, p_addr, p_be, p_wdata,
        output if_addr, if_req,
        output dma_start, dma_addr, dma_len,
        output dma_wvalid, dma_wdata,
`ifdef LS_PARITY_EN
        input  p_perr, if_perr,
`endif
        input  p_rdata, p_rvalid, if_data, if_valid,
        input  dma_wready, dma_busy, dma_done
    );

    modport slave (
        input  p_req, p_we, p_addr, p_be, p_wdata,
        input  if_addr, if_req,
        input  dma_start, dma_addr, dma_len,
        input  dma_wvalid, dma_wdata,
`ifdef LS_PARITY_EN
        output p_perr, if_perr,
`endif
        output p_rdata, p_rvalid, if_data, if_valid,
        output dma_wready, dma_busy, dma_done
    );

endinterface

// File: rtl/spu_local_store_dma.sv
// spu_ls_dma: burst-fill FSM feeding the lowest-priority write slot.
// Beats stall whenever port 0 is writing in the same cycle.
module spu_ls_dma #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 14,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [LEN_W-1:0]  len,
    input  logic              wvalid,
    input  logic [DATA_W-1:0] wdata,
    input  logic              p0_wr,
    output logic              wready,
    output logic              busy,
    output logic              done,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wd
);
    import spu_ls_pkg::*;

    dma_state_t        state_q, state_d;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  cnt_q;
    logic [LEN_W-1:0]  idx_q;
    logic              beat;

    // State, burst base/length capture and beat index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start) begin
                base_q <= addr;
                cnt_q  <= len;
                idx_q  <= '0;
            end else if (beat) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Next state and handshake outputs.
    always_comb begin
        state_d = state_q;
        wready  = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        beat    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = BURST;
            end
            BURST: begin
                busy   = 1'b1;
                wready = !p0_wr;
                beat   = wvalid && !p0_wr;
                if (beat && idx_q == cnt_q) state_d = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign we    = beat;
    assign waddr = base_q + ADDR_W'(idx_q);
    assign wd    = wdata;

endmodule

// File: rtl/spu_local_store.sv
// spu_local_store: N-port quadword local store with fetch port and DMA fill.
// Optional macro LS_PARITY_EN adds per-byte even parity and error flags.
module spu_local_store #(
    parameter int DATA_W    = 128,
    parameter int DEPTH     = 16384,
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = $clog2(DEPTH),
    parameter int LEN_W     = 8
) (
    input  logic clk,
    input  logic rst_n,
    spu_local_store_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];
`ifdef LS_PARITY_EN
    logic [BE_W-1:0]   par [DEPTH];

    function automatic logic [BE_W-1:0] bpar(input logic [DATA_W-1:0] d);
        logic [BE_W-1:0] r;
        for (int b = 0; b < BE_W; b++) r[b] = ^d[b*8 +: 8];
        return r;
    endfunction
`endif

    logic              dma_we;
    logic [ADDR_W-1:0] dma_waddr;
    logic [DATA_W-1:0] dma_wd;

    spu_ls_dma #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .LEN_W (LEN_W)
    ) u_dma (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.dma_start),
        .addr  (bus.dma_addr),
        .len   (bus.dma_len),
        .wvalid(bus.dma_wvalid),
        .wdata (bus.dma_wdata),
        .p0_wr (bus.p_req[0] & bus.p_we[0]),
        .wready(bus.dma_wready),
        .busy  (bus.dma_busy),
        .done  (bus.dma_done),
        .we    (dma_we),
        .waddr (dma_waddr),
        .wd    (dma_wd)
    );

    // Array writes: lowest priority first so later assignments win per byte.
    always_ff @(posedge clk) begin
        if (dma_we) begin
            mem[dma_waddr] <= dma_wd;
`ifdef LS_PARITY_EN
            par[dma_waddr] <= bpar(dma_wd);
`endif
        end
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (bus.p_req[i] && bus.p_we[i]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (bus.p_be[i*BE_W + b]) begin
                        mem[bus.p_addr[i*ADDR_W +: ADDR_W]][b*8 +: 8]
                            <= bus.p_wdata[i*DATA_W + b*8 +: 8];
`ifdef LS_PARITY_EN
                        par[bus.p_addr[i*ADDR_W +: ADDR_W]][b]
                            <= ^bus.p_wdata[i*DATA_W + b*8 +: 8];
`endif
                    end
                end
            end
        end
    end

    // Registered read-first data and fetch ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.p_rdata  <= '0;
            bus.p_rvalid <= '0;
            bus.if_data  <= '0;
            bus.if_valid <= 1'b0;
`ifdef LS_PARITY_EN
            bus.p_perr   <= '0;
            bus.if_perr  <= 1'b0;
`endif
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                bus.p_rvalid[i] <= bus.p_req[i] && !bus.p_we[i];
                if (bus.p_req[i] && !bus.p_we[i])
                    bus.p_rdata[i*DATA_W +: DATA_W]
                        <= mem[bus.p_addr[i*ADDR_W +: ADDR_W]];
`ifdef LS_PARITY_EN
                bus.p_perr[i] <= bus.p_req[i] && !bus.p_we[i] &&
                    |(par[bus.p_addr[i*ADDR_W +: ADDR_W]] ^
                      bpar(mem[bus.p_addr[i*ADDR_W +: ADDR_W]]));
`endif
            end
            bus.if_valid <= bus.if_req;
            if (bus.if_req) bus.if_data <= mem[bus.if_addr];
`ifdef LS_PARITY_EN
            bus.if_perr <= bus.if_req &&
                |(par[bus.if_addr] ^ bpar(mem[bus.if_addr]));
`endif
        end
    end

endmodule

// File: tb/tb_spu_local_store.sv
// tb_spu_local_store: directed checks of reads, collisions and DMA bursts.
// Parity checks are compiled in only with LS_PARITY_EN.
module tb_spu_local_store;
    localparam int DW    = 128;
    localparam int DEPTH = 16384;
    localparam int NP    = 2;
    localparam int AW    = 14;
    localparam int LW    = 8;
    localparam int BW    = DW / 8;

    localparam logic [DW-1:0] OLD = {8{16'h1111}};
    localparam logic [DW-1:0] D1  =
        128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [DW-1:0] AAS = {16{8'hAA}};
    localparam logic [DW-1:0] FIVES = {16{8'h55}};
    localparam logic [DW-1:0] MIX =
        {{12{8'h55}}, {4{8'hAA}}};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spu_local_store_if #(
        .NUM_PORTS(NP), .DATA_W(DW), .ADDR_W(AW), .LEN_W(LW)
    ) bus ();

    spu_local_store #(
        .DATA_W(DW), .DEPTH(DEPTH), .NUM_PORTS(NP),
        .ADDR_W(AW), .LEN_W(LW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bd(input int tag, input int k);
        return {4{tag[15:0], k[15:0]}};
    endfunction

    task automatic idle();
        bus.p_req = '0;
        bus.p_we = '0;
        bus.p_addr = '0;
        bus.p_be = '0;
        bus.p_wdata = '0;
        bus.if_req = 1'b0;
        bus.if_addr = '0;
        bus.dma_start = 1'b0;
        bus.dma_addr = '0;
        bus.dma_len = '0;
        bus.dma_wvalid = 1'b0;
        bus.dma_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_wr(input int p, input logic [AW-1:0] a,
                          input logic [BW-1:0] be,
                          input logic [DW-1:0] d);
        bus.p_req[p] = 1'b1;
        bus.p_we[p] = 1'b1;
        bus.p_addr[p*AW +: AW] = a;
        bus.p_be[p*BW +: BW] = be;
        bus.p_wdata[p*DW +: DW] = d;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.p_req[p] = 1'b1;
        bus.p_we[p] = 1'b0;
        bus.p_addr[p*AW +: AW] = a;
    endtask

    task automatic write(input int p, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
        set_wr(p, a, '1, d);
        tick();
        idle();
    endtask

    task automatic read_chk(input string tag, input int p,
                            input logic [AW-1:0] a,
                            input logic [DW-1:0] exp);
        set_rd(p, a);
        tick();
        check({tag, "_rvalid"}, DW'(bus.p_rvalid[p]), 1);
        check(tag, bus.p_rdata[p*DW +: DW], exp);
        idle();
    endtask

    task automatic fetch_chk(input string tag, input logic [AW-1:0] a,
                             input logic [DW-1:0] exp);
        bus.if_req = 1'b1;
        bus.if_addr = a;
        tick();
        check({tag, "_valid"}, DW'(bus.if_valid), 1);
        check(tag, bus.if_data, exp);
        idle();
    endtask

    task automatic dma_burst(input logic [AW-1:0] base, input int n,
                             input int tag, input int stall_at,
                             input int stall_n, input int abort_at);
        int k;
        int sc;
        int stalls;
        int cyc;
        logic take;
        k = 0;
        sc = 0;
        stalls = 0;
        cyc = 0;
        bus.dma_start = 1'b1;
        bus.dma_addr = base;
        bus.dma_len = LW'(n - 1);
        tick();
        bus.dma_start = 1'b0;
        check("dma_busy_rise", DW'(bus.dma_busy), 1);
        while (k < n && cyc < 64) begin
            if (abort_at >= 0 && k == abort_at) break;
            bus.dma_wvalid = 1'b1;
            bus.dma_wdata = bd(tag, k);
            if (k == stall_at && sc < stall_n) begin
                set_wr(0, 200, '1, '0);
                sc++;
            end
            #1;
            take = bus.dma_wready;
            if (!take) stalls++;
            tick();
            if (take) k++;
            bus.p_req[0] = 1'b0;
            bus.p_we[0] = 1'b0;
            cyc++;
        end
        bus.dma_wvalid = 1'b0;
        if (stall_n > 0)
            check("dma_stall_cycles", DW'(stalls), DW'(stall_n));
        if (abort_at < 0) begin
            check("dma_beats", DW'(k), DW'(n));
            check("dma_done_pulse", DW'(bus.dma_done), 1);
            check("dma_busy_fall", DW'(bus.dma_busy), 0);
            tick();
            check("dma_done_once", DW'(bus.dma_done), 0);
        end
    endtask

    initial begin
        int dones;
        idle();
        #22;
        check("rst_p_rdata", bus.p_rdata[DW-1:0], '0);
        check("rst_p_rvalid", DW'(bus.p_rvalid), 0);
        check("rst_if_data", bus.if_data, '0);
        check("rst_if_valid", DW'(bus.if_valid), 0);
        check("rst_wready", DW'(bus.dma_wready), 0);
        check("rst_busy", DW'(bus.dma_busy), 0);
        check("rst_done", DW'(bus.dma_done), 0);
`ifdef LS_PARITY_EN
        check("rst_p_perr", DW'(bus.p_perr), 0);
        check("rst_if_perr", DW'(bus.if_perr), 0);
`endif
        rst_n = 1'b1;
        tick();

        write(0, 5, OLD);
        set_wr(0, 5, '1, D1);
        set_rd(1, 5);
        tick();
        check("rd_first_old", bus.p_rdata[DW +: DW], OLD);
        check("rd_first_rvalid", DW'(bus.p_rvalid[1]), 1);
        check("wr_no_rvalid", DW'(bus.p_rvalid[0]), 0);
        idle();
        read_chk("rd_after_wr", 1, 5, D1);
        tick();
        check("rvalid_idle", DW'(bus.p_rvalid[1]), 0);
        check("rdata_hold", bus.p_rdata[DW +: DW], D1);
        fetch_chk("fetch5", 5, D1);

        set_wr(0, 9, 16'h000F, AAS);
        set_wr(1, 9, 16'hFFFF, FIVES);
        tick();
        idle();
        fetch_chk("collide", 9, MIX);

        set_wr(0, 9, '1, D1);
        bus.if_req = 1'b1;
        bus.if_addr = 9;
        tick();
        check("fetch_rd_first", bus.if_data, MIX);
        idle();
        read_chk("after_fetch_wr", 0, 9, D1);

        write(0, 2, OLD);
        dma_burst(AW'(DEPTH - 2), 4, 1, -1, 0, -1);
        read_chk("wrap0", 0, AW'(DEPTH - 2), bd(1, 0));
        read_chk("wrap1", 1, AW'(DEPTH - 1), bd(1, 1));
        read_chk("wrap2", 0, 0, bd(1, 2));
        fetch_chk("wrap3", 1, bd(1, 3));
        read_chk("wrap_untouched", 1, 2, OLD);

        write(0, 106, OLD);
        dma_burst(100, 6, 2, 2, 3, -1);
        for (int i = 0; i < 6; i++)
            read_chk($sformatf("stall_line%0d", i), i % 2,
                     AW'(100 + i), bd(2, i));
        read_chk("stall_after", 0, 106, OLD);
        read_chk("stall_p0_wr", 1, 200, '0);

        write(0, 302, OLD);
        dma_burst(300, 8, 3, -1, 0, 2);
        rst_n = 1'b0;
        #1;
        check("abort_busy", DW'(bus.dma_busy), 0);
        check("abort_wready", DW'(bus.dma_wready), 0);
        idle();
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(bus.dma_done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            dones += int'(bus.dma_done);
        end
        check("abort_no_done", DW'(dones), 0);
        read_chk("abort_kept0", 0, 300, bd(3, 0));
        read_chk("abort_kept1", 1, 301, bd(3, 1));
        read_chk("abort_unwritten", 0, 302, OLD);
        dma_burst(400, 1, 4, -1, 0, -1);
        read_chk("restart_line", 1, 400, bd(4, 0));

`ifdef LS_PARITY_EN
        write(0, 3, D1);
        bus.if_req = 1'b1;
        bus.if_addr = 3;
        tick();
        check("perr_clean", DW'(bus.if_perr), 0);
        idle();
        dut.mem[3][7:0] = ~dut.mem[3][7:0];
        bus.if_req = 1'b1;
        bus.if_addr = 3;
        tick();
        check("perr_valid", DW'(bus.if_valid), 1);
        check("perr_flag", DW'(bus.if_perr), 1);
        idle();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
